param_bus_ctrl: RTL

//   Registered, parametrised datapath bus. Selects one of NSRC source words onto the shared CPU bus using
//   one-hot "out" enables from the control unit. Adds three things: a 1-cycle registered output, hold of
//   the last value when no source is enabled, and detection/logging of conflicts (more than one enable).

---
 rtl/bus_pkg.sv | 34 +++
 rtl/bus_prio_enc.sv | 22 ++
 rtl/param_bus_ctrl.sv | 103 ++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// Source slot indices and default dimensions shared by the bus controller and its users.
package bus_pkg;
   localparam int NSRC_DEFAULT  = 24;
   localparam int WIDTH_DEFAULT = 32;

   localparam int SRC_R0     = 0;
   localparam int SRC_R1     = 1;
   localparam int SRC_R2     = 2;
   localparam int SRC_R3     = 3;
   localparam int SRC_R4     = 4;
   localparam int SRC_R5     = 5;
   localparam int SRC_R6     = 6;
   localparam int SRC_R7     = 7;
   localparam int SRC_R8     = 8;
   localparam int SRC_R9     = 9;
   localparam int SRC_R10    = 10;
   localparam int SRC_R11    = 11;
   localparam int SRC_R12    = 12;
   localparam int SRC_R13    = 13;
   localparam int SRC_R14    = 14;
   localparam int SRC_R15    = 15;
   localparam int SRC_HI     = 16;
   localparam int SRC_LO     = 17;
   localparam int SRC_ZHI    = 18;
   localparam int SRC_ZLO    = 19;
   localparam int SRC_PC     = 20;
   localparam int SRC_MDR    = 21;
   localparam int SRC_INPORT = 22;
   localparam int SRC_C      = 23;

   function automatic int idx_bits(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/bus_prio_enc.sv
// Lowest-index-wins priority encoder over the source enables, with any/multi flags.
module bus_prio_enc
   import bus_pkg::*;
#(
   parameter  int NSRC = NSRC_DEFAULT,
   localparam int IDXW = idx_bits(NSRC)
) (
   input  logic [NSRC-1:0] req,
   output logic [IDXW-1:0] idx,
   output logic            any,
   output logic            multi
);
   always_comb begin
      idx = '0;
      // Scan downward so the lowest asserted index is the last to write idx.
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (req[i]) idx = IDXW'(i);
      end
      any   = |req;
      multi = |(req & (req - NSRC'(1)));
   end
endmodule

// File: rtl/param_bus_ctrl.sv
// Registered shared CPU bus: one-hot source select, hold-on-idle and conflict logging.
module param_bus_ctrl
   import bus_pkg::*;
#(
   parameter  int WIDTH     = WIDTH_DEFAULT,
   parameter  int NSRC      = NSRC_DEFAULT,
   parameter  int HOLD_LAST = 1,
   parameter  int CNTW      = 8,
   localparam int IDXW      = idx_bits(NSRC)
) (
   input  logic                  clk,
   input  logic                  clr,
   input  logic [NSRC*WIDTH-1:0] src_data,
   input  logic [NSRC-1:0]       src_out,
   input  logic                  err_clear,
   output logic [WIDTH-1:0]      bus,
   output logic                  bus_valid,
   output logic [IDXW-1:0]       bus_src,
   output logic                  conflict,
   output logic                  conflict_sticky,
   output logic [CNTW-1:0]       conflict_cnt,
   output logic [IDXW-1:0]       first_conflict_src
);
   logic [IDXW-1:0]  win_idx;
   logic             win_any, win_multi;
   logic [WIDTH-1:0] sel_data;

   logic [WIDTH-1:0] bus_q, bus_d;
   logic             valid_q, valid_d;
   logic [IDXW-1:0]  src_q, src_d;
   logic             conf_q, conf_d;
   logic             sticky_q, sticky_d;
   logic [CNTW-1:0]  cnt_q, cnt_d;
   logic [IDXW-1:0]  first_q, first_d;

   bus_prio_enc #(.NSRC(NSRC)) u_enc (
      .req   (src_out),
      .idx   (win_idx),
      .any   (win_any),
      .multi (win_multi)
   );

   always_comb begin
      sel_data = '0;
      for (int i = 0; i < NSRC; i++) begin
         if (win_idx == IDXW'(i)) sel_data = src_data[i*WIDTH +: WIDTH];
      end
   end

   always_comb begin
      bus_d    = bus_q;
      valid_d  = win_any;
      src_d    = src_q;
      conf_d   = win_multi;
      sticky_d = sticky_q;
      cnt_d    = cnt_q;
      first_d  = first_q;
      if (win_any) begin
         bus_d = sel_data;
         src_d = win_idx;
      end else if (HOLD_LAST == 0) begin
         bus_d = '0;
      end
      // Clearing the error log wins over a conflict landing in the same cycle.
      if (err_clear) begin
         sticky_d = 1'b0;
         cnt_d    = '0;
         first_d  = '0;
      end else if (win_multi) begin
         sticky_d = 1'b1;
         if (!(&cnt_q)) cnt_d = cnt_q + CNTW'(1);
         if (!sticky_q) first_d = win_idx;
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         bus_q    <= '0;
         valid_q  <= 1'b0;
         src_q    <= '0;
         conf_q   <= 1'b0;
         sticky_q <= 1'b0;
         cnt_q    <= '0;
         first_q  <= '0;
      end else begin
         bus_q    <= bus_d;
         valid_q  <= valid_d;
         src_q    <= src_d;
         conf_q   <= conf_d;
         sticky_q <= sticky_d;
         cnt_q    <= cnt_d;
         first_q  <= first_d;
      end
   end

   assign bus                = bus_q;
   assign bus_valid          = valid_q;
   assign bus_src            = src_q;
   assign conflict           = conf_q;
   assign conflict_sticky    = sticky_q;
   assign conflict_cnt       = cnt_q;
   assign first_conflict_src = first_q;
endmodule
